// File: rtl/fir_pkg.sv
// Shared types and constants for the 2-parallel FIR filter and its downstream stages.
package fir_pkg;

  localparam int IN_W  = 40;
  localparam int OUT_W = 16;

  typedef logic signed [IN_W-1:0]  fir_out_t;
  typedef logic signed [OUT_W-1:0] fir_q_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } peak_state_e;

endpackage

// File: rtl/fir_sat_requant.sv
// Combinational requantizer: arithmetic right shift, then clamp to the signed OUT_W range.
module fir_sat_requant #(
  parameter int IN_W       = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 14
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  import fir_pkg::*;

  localparam logic signed [IN_W-1:0] Q_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] Q_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  always_comb begin
    shifted = din >>> FRAC_SHIFT;
    if (shifted > Q_MAX) begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < Q_MIN) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_peak_detector.sv
// Settle-then-measure peak tracker on both FIR output lanes; publishes raw and requantized peak.
// Optional: define FIR_PEAK_ABS_EN to compare lane magnitudes instead of signed values.
module fir_peak_detector #(
  parameter int IN_W          = fir_pkg::IN_W,
  parameter int OUT_W         = fir_pkg::OUT_W,
  parameter int FRAC_SHIFT    = 14,
  parameter int SETTLE_CYCLES = 340,
  parameter int WINDOW_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [IN_W-1:0]  inp [1:0],
  output logic                    busy,
  output logic                    peak_valid,
  output logic signed [IN_W-1:0]  peak,
  output logic signed [OUT_W-1:0] peak_q
);
  import fir_pkg::*;

  localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);

  peak_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [IN_W-1:0]   acc_q, acc_d;
  logic signed [IN_W-1:0]   peak_raw_q, peak_raw_d;
  logic signed [OUT_W-1:0]  peak_sat_q, peak_sat_d;
  logic                     valid_q, valid_d;

  logic signed [IN_W-1:0]   lane0, lane1, lane_max, acc_cand;
  logic signed [OUT_W-1:0]  cand_sat;

`ifdef FIR_PEAK_ABS_EN
  // Most negative value has no positive twin, so it clamps to the largest positive.
  function automatic logic signed [IN_W-1:0] lane_val(input logic signed [IN_W-1:0] x);
    if (x == {1'b1, {(IN_W-1){1'b0}}}) begin
      return {1'b0, {(IN_W-1){1'b1}}};
    end else if (x < 0) begin
      return -x;
    end
    return x;
  endfunction
`else
  function automatic logic signed [IN_W-1:0] lane_val(input logic signed [IN_W-1:0] x);
    return x;
  endfunction
`endif

  // The first measure edge loads unconditionally so stale accumulator data never wins.
  always_comb begin
    lane0    = lane_val(inp[0]);
    lane1    = lane_val(inp[1]);
    lane_max = (lane1 > lane0) ? lane1 : lane0;
    if (cnt_q == '0) begin
      acc_cand = lane_max;
    end else begin
      acc_cand = (lane_max > acc_q) ? lane_max : acc_q;
    end
  end

  fir_sat_requant #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_requant (
    .din  (acc_cand),
    .dout (cand_sat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    peak_raw_d = peak_raw_q;
    peak_sat_d = peak_sat_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? MEASURE : SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_cand;
          if (cnt_q == WINDOW_LAST) begin
            peak_raw_d = acc_cand;
            peak_sat_d = cand_sat;
            valid_d    = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      peak_raw_q <= '0;
      peak_sat_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      peak_raw_q <= peak_raw_d;
      peak_sat_q <= peak_sat_d;
      valid_q    <= valid_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign peak_valid = valid_q;
  assign peak       = peak_raw_q;
  assign peak_q     = peak_sat_q;

endmodule
